load_store_unit: RTL and testbench

Load/store front end between the CPU execute stage and the word-addressed data memory. Accepts one byte-addressed request at a time, performs byte/halfword/word loads and stores, and drives the memory's `re`/`we`/`rdy` handshake. Sub-word stores use read-modify-write. Load data is returned sign- or zero-extended. Misaligned or out-of-range accesses are rejected without touching memory.

---
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store front end between execute stage and word-addressed data memory.
// Byte/half/word loads (sign/zero extended) and stores (sub-word via read-modify-write).
// Ports: clk, rst (sync, active-low); req_* request channel (valid/ready);
//   resp_* one-cycle completion; mem_* strobe/rdy memory handshake.
// Option: define LSU_TIMEOUT_EN to bound wait states by TIMEOUT cycles.
module load_store_unit #(
   parameter int MEM_WORDS = 4029,
   parameter int TIMEOUT   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_w,
   input  logic [31:0] mem_data_r,
   input  logic        mem_rdy
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic        r_uns;
   logic [1:0]  r_size;
   logic [1:0]  r_lane;
   logic [15:0] r_wdata;
   logic        w_accept;
   logic        w_req_err;
   logic        w_tmo;
   logic        w_wait;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;
   logic [31:0] w_merge;
   logic        w_resp_err;
   logic [31:0] w_resp_rdata;

   assign w_accept  = req_valid & req_ready;
   assign w_wait    = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
   assign w_req_err = (req_size == 2'b11)
                    | ((req_size == 2'b01) & req_addr[0])
                    | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                    | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

`ifdef LSU_TIMEOUT_EN
   logic [31:0] r_cnt;

   // Counts cycles spent in the current wait state; zero on entry.
   always_ff @(posedge clk) begin
      if (!rst) r_cnt <= '0;
      else if (w_wait) r_cnt <= r_cnt + 32'd1;
      else r_cnt <= '0;
   end

   assign w_tmo = w_wait && !mem_rdy && (r_cnt >= 32'(TIMEOUT - 1));
`else
   assign w_tmo = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_req_err) w_next = S_RESP;
               else if (req_we && req_size == 2'b10) w_next = S_WR;
               else w_next = S_RD;
            end
         end
         S_RD:      w_next = S_RD_WAIT;
         S_RD_WAIT: begin
            if (mem_rdy) w_next = r_we ? S_WR : S_RESP;
            else if (w_tmo) w_next = S_RESP;
         end
         S_WR:      w_next = S_WR_WAIT;
         S_WR_WAIT: begin
            if (mem_rdy || w_tmo) w_next = S_RESP;
         end
         S_RESP:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs
   always_comb begin
      w_byte  = mem_data_r[{r_lane, 3'b000} +: 8];
      w_half  = mem_data_r[{r_lane[1], 4'b0000} +: 16];
      w_ext   = mem_data_r;
      w_merge = mem_data_r;
      unique case (r_size)
         2'b00: w_ext = r_uns ? {24'b0, w_byte}
                              : {{24{w_byte[7]}}, w_byte};
         2'b01: w_ext = r_uns ? {16'b0, w_half}
                              : {{16{w_half[15]}}, w_half};
         default: w_ext = mem_data_r;
      endcase
      if (r_size == 2'b00)
         w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      else
         w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
      w_resp_err   = 1'b0;
      w_resp_rdata = '0;
      if (r_state == S_IDLE && w_accept && w_req_err) w_resp_err = 1'b1;
      if (r_state == S_RD_WAIT && mem_rdy && !r_we) w_resp_rdata = w_ext;
      if (w_tmo) w_resp_err = 1'b1;
   end

   // Registered outputs and latched request fields
   always_ff @(posedge clk) begin
      if (!rst) begin
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= '0;
         mem_re      <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_data_w  <= '0;
         r_we        <= 1'b0;
         r_uns       <= 1'b0;
         r_size      <= 2'b00;
         r_lane      <= 2'b00;
         r_wdata     <= '0;
      end else begin
         req_ready  <= (w_next == S_IDLE);
         mem_re     <= (w_next == S_RD) || (w_next == S_RD_WAIT);
         mem_we     <= (w_next == S_WR) || (w_next == S_WR_WAIT);
         resp_valid <= (w_next == S_RESP);
         resp_err   <= w_resp_err;
         resp_rdata <= w_resp_rdata;
         if (w_accept) begin
            r_we        <= req_we;
            r_uns       <= req_unsigned;
            r_size      <= req_size;
            r_lane      <= req_addr[1:0];
            r_wdata     <= req_wdata[15:0];
            mem_address <= {2'b00, req_addr[31:2]};
            if (req_we && req_size == 2'b10) mem_data_w <= req_wdata;
         end
         // Sub-word store: merge into the word just read
         if (r_state == S_RD_WAIT && mem_rdy && r_we) mem_data_w <= w_merge;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

   logic        clk = 0;
   logic        rst = 0;
   logic        req_valid = 0;
   logic        req_ready;
   logic        req_we = 0;
   logic [1:0]  req_size = 0;
   logic        req_unsigned = 0;
   logic [31:0] req_addr = 0;
   logic [31:0] req_wdata = 0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_address;
   logic [31:0] mem_data_w;
   logic [31:0] mem_data_r;
   logic        mem_rdy;
   logic        rdy_en = 1;

   logic [31:0] tmem [64];

   int          n_pass = 0;
   int          n_total = 0;
   int          lat;
   logic [31:0] rdv;
   logic        erv;
   logic        both;
   logic        strobe;
   logic        rdy1;
   logic [31:0] adr;
   logic [1:0]  sq [1:8];

   load_store_unit #(.MEM_WORDS(4029), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_re(mem_re), .mem_we(mem_we),
      .mem_address(mem_address), .mem_data_w(mem_data_w),
      .mem_data_r(mem_data_r), .mem_rdy(mem_rdy)
   );

   always #5 clk = ~clk;

   assign mem_rdy    = rdy_en;
   assign mem_data_r = tmem[mem_address[5:0]];

   always @(posedge clk) begin
      if (mem_we && mem_rdy) tmem[mem_address[5:0]] = mem_data_w;
   end

   // Issue one request from an IDLE cycle and follow it to its response.
   task automatic do_req(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, input int rdy_on);
      req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd; req_valid = 1;
      @(posedge clk); #1;
      req_valid = 0;
      lat = -1; rdv = 0; erv = 0; both = 0; strobe = 0; adr = 0;
      rdy1 = req_ready;
      for (int i = 1; i <= 8; i++) sq[i] = 2'b00;
      for (int n = 1; n <= 40; n++) begin
         if (n <= 8) sq[n] = {mem_re, mem_we};
         if (mem_re && mem_we) both = 1;
         if (mem_re || mem_we) begin strobe = 1; adr = mem_address; end
         if (n == rdy_on) rdy_en = 1;
         if (resp_valid) begin
            lat = n; rdv = resp_rdata; erv = resp_err;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 0;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
      else n_pass++;
      n_total++;
      if ({resp_valid, resp_err, mem_re, mem_we} !== 4'b0000)
         $display("FAIL reset_flags got %b want 0000", {resp_valid, resp_err, mem_re, mem_we});
      else n_pass++;
      n_total++;
      if ({resp_rdata, mem_address, mem_data_w} !== 96'h0)
         $display("FAIL reset_data got %h want 0", {resp_rdata, mem_address, mem_data_w});
      else n_pass++;
      rst = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_word;
      do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
      n_total++;
      if (lat !== 3) $display("FAIL wst_lat got %0d want 3", lat); else n_pass++;
      n_total++;
      if (adr !== 32'd4) $display("FAIL wst_addr got %h want 4", adr); else n_pass++;
      n_total++;
      if (tmem[4] !== 32'hDEADBEEF) $display("FAIL wst_mem got %h want deadbeef", tmem[4]);
      else n_pass++;
      n_total++;
      if ({erv, rdv} !== 33'h0) $display("FAIL wst_resp got %h want 0", {erv, rdv}); else n_pass++;
      n_total++;
      if (rdy1 !== 1'b0) $display("FAIL busy_ready got %b want 0", rdy1); else n_pass++;
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0);
      n_total++;
      if (lat !== 3) $display("FAIL wld_lat got %0d want 3", lat); else n_pass++;
      n_total++;
      if (adr !== 32'd4) $display("FAIL wld_addr got %h want 4", adr); else n_pass++;
      n_total++;
      if (rdv !== 32'hDEADBEEF || erv !== 1'b0)
         $display("FAIL wld_data got %h/%b want deadbeef/0", rdv, erv);
      else n_pass++;
   endtask

   task automatic test_sub_load;
      tmem[4] = 32'h0000_80FF;
      do_req(0, 2'b00, 0, 32'h11, 32'h0, 0);
      n_total++;
      if (rdv !== 32'hFFFFFF80) $display("FAIL lb_signed got %h want ffffff80", rdv); else n_pass++;
      do_req(0, 2'b00, 1, 32'h11, 32'h0, 0);
      n_total++;
      if (rdv !== 32'h00000080) $display("FAIL lb_unsigned got %h want 00000080", rdv); else n_pass++;
      do_req(0, 2'b01, 0, 32'h10, 32'h0, 0);
      n_total++;
      if (rdv !== 32'hFFFF80FF) $display("FAIL lh_signed got %h want ffff80ff", rdv); else n_pass++;
      do_req(0, 2'b00, 0, 32'h10, 32'h0, 0);
      n_total++;
      if (rdv !== 32'hFFFFFFFF) $display("FAIL lb_lane0 got %h want ffffffff", rdv); else n_pass++;
   endtask

   task automatic test_sub_store;
      tmem[4] = 32'h11223344;
      do_req(1, 2'b00, 0, 32'h12, 32'hFFFFFFAB, 0);
      n_total++;
      if (tmem[4] !== 32'h11AB3344) $display("FAIL sb_mem got %h want 11ab3344", tmem[4]);
      else n_pass++;
      n_total++;
      if (lat !== 5) $display("FAIL sb_lat got %0d want 5", lat); else n_pass++;
      n_total++;
      if ({sq[1], sq[2], sq[3], sq[4], sq[5]} !== 10'b10_10_01_01_00)
         $display("FAIL sb_seq got %b want 1010010100", {sq[1], sq[2], sq[3], sq[4], sq[5]});
      else n_pass++;
      n_total++;
      if (both !== 1'b0) $display("FAIL sb_both got %b want 0", both); else n_pass++;
      do_req(1, 2'b01, 0, 32'h12, 32'h00005566, 0);
      n_total++;
      if (tmem[4] !== 32'h55663344) $display("FAIL sh_mem got %h want 55663344", tmem[4]);
      else n_pass++;
   endtask

   task automatic test_errors;
      do_req(0, 2'b01, 0, 32'h13, 32'h0, 0);
      n_total++;
      if (lat !== 1 || erv !== 1'b1 || strobe !== 1'b0)
         $display("FAIL err_half got %0d/%b/%b want 1/1/0", lat, erv, strobe);
      else n_pass++;
      do_req(0, 2'b10, 0, 32'h3EF4, 32'h0, 0);
      n_total++;
      if (lat !== 1 || erv !== 1'b1 || strobe !== 1'b0)
         $display("FAIL err_range got %0d/%b/%b want 1/1/0", lat, erv, strobe);
      else n_pass++;
      do_req(1, 2'b11, 0, 32'h10, 32'h0, 0);
      n_total++;
      if (erv !== 1'b1 || strobe !== 1'b0 || rdv !== 32'h0)
         $display("FAIL err_size got %b/%b/%h want 1/0/0", erv, strobe, rdv);
      else n_pass++;
      do_req(1, 2'b10, 0, 32'h12, 32'h0, 0);
      n_total++;
      if (erv !== 1'b1 || strobe !== 1'b0)
         $display("FAIL err_walign got %b/%b want 1/0", erv, strobe);
      else n_pass++;
      tmem[60] = 32'h12345678;
      do_req(0, 2'b10, 0, 32'h3EF0, 32'h0, 0);
      n_total++;
      if (erv !== 1'b0 || rdv !== 32'h12345678)
         $display("FAIL last_word got %b/%h want 0/12345678", erv, rdv);
      else n_pass++;
   endtask

   task automatic test_stall;
      tmem[4] = 32'hCAFEF00D;
      rdy_en = 0;
`ifdef LSU_TIMEOUT_EN
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0);
      n_total++;
      if (lat !== 6 || erv !== 1'b1 || rdv !== 32'h0 || sq[6] !== 2'b00)
         $display("FAIL timeout got %0d/%b/%h/%b want 6/1/0/00", lat, erv, rdv, sq[6]);
      else n_pass++;
      rdy_en = 1;
`else
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 11);
      n_total++;
      if (lat !== 12 || erv !== 1'b0 || rdv !== 32'hCAFEF00D)
         $display("FAIL stall got %0d/%b/%h want 12/0/cafef00d", lat, erv, rdv);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_mid;
      int bad;
      rdy_en = 0;
      req_we = 0; req_size = 2'b10; req_addr = 32'h10; req_valid = 1;
      @(posedge clk); #1;
      req_valid = 0;
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      n_total++;
      if ({req_ready, mem_re, mem_we, resp_valid} !== 4'b1000)
         $display("FAIL rst_mid got %b want 1000", {req_ready, mem_re, mem_we, resp_valid});
      else n_pass++;
      rst = 1;
      rdy_en = 1;
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (resp_valid) bad++;
      end
      n_total++;
      if (bad !== 0) $display("FAIL rst_noresp got %0d want 0", bad); else n_pass++;
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0);
      n_total++;
      if (lat !== 3 || rdv !== 32'hCAFEF00D)
         $display("FAIL rst_recover got %0d/%h want 3/cafef00d", lat, rdv);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) tmem[i] = 32'h0;
      test_reset;
      test_word;
      test_sub_load;
      test_sub_store;
      test_errors;
      test_stall;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
